alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-requester arbiter and sequencer for the shared 32-bit combinational ALU (ops ADD, SUB, AND, OR, XOR, LUI-shift). It accepts operations over valid/ready handshakes, grants them round-robin, and drives the ALU operand and opcode inputs from registers. It captures the ALU Result and Zero, then returns them to the winning requester over a response handshake. It sits between the ALU and its clients, e.g. the main datapath and a multi-cycle helper unit.

## Interface
- WIDTH, 32, operand/result width; must match the ALU.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- r0_valid / r1_valid  in  1  request valid, requester 0 / 1.
- r0_op / r1_op  in  3  ALU opcode: 000 ADD, 100 SUB, 001 AND, 101 OR, 010 XOR, 110 LUI.
- r0_a, r0_b / r1_a, r1_b  in  WIDTH  operands.
- r0_ready / r1_ready  out  1  request accepted this cycle.
- resp_valid  out  2  one-hot response valid; bit i belongs to requester i.
- resp_ready  in  2  bit i means requester i takes the response.
- resp_result  out  WIDTH  captured ALU Result.
- resp_zero  out  1  captured ALU Zero.
- resp_err  out  1  illegal opcode (see Configuration).
- busy  out  1  high in any state other than IDLE.
- alu_a, alu_b  out  WIDTH  registered drive to ALU A and B.
- alu_op  out  3  registered drive to ALU_operation.
- alu_result  in  WIDTH  ALU Result.
- alu_zero  in  1  ALU Zero.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The winner is chosen combinationally from r0_valid and r1_valid and the priority pointer `prio`.
  - If only one requester is valid, it wins. If both are valid, requester `prio` wins.
  - r*_ready is high only for the winner and only in IDLE; it is a Mealy output.
  - On valid&ready, the edge latches op/a/b into alu_op/alu_a/alu_b, records the winner id, sets `prio` to the other requester, and moves to EXEC.
- EXEC: the edge captures alu_result into resp_result and alu_zero into resp_zero, then moves to RESP.
- RESP:
  - resp_valid[id] is held high, and resp_result/resp_zero/resp_err are held stable.
  - On resp_valid[id]&resp_ready[id], move to IDLE. resp_ready of the non-owner is ignored.
- alu_a/alu_b/alu_op hold their last values outside EXEC; no zeroing is required.
- Requests are never dropped. A requester holds valid and its fields stable until it sees ready. A loser stays pending, and round-robin guarantees it the next grant.
- `prio` changes only on a grant, not on idle cycles.

## Timing
- Reset values:
  - r0_ready = r1_ready = 0.
  - resp_valid = 00, resp_result = 0, resp_zero = 0, resp_err = 0, busy = 0.
  - alu_a = alu_b = 0, alu_op = 000.
  - State = IDLE, `prio` = 0.
- Latency: accept in cycle N gives EXEC in N+1 and resp_valid high in N+2.
- Minimum occupancy is 3 cycles per operation. A new accept is possible in the cycle the FSM is back in IDLE, so back-to-back throughput is 1 op per 3 cycles.
- resp_valid stays high indefinitely until resp_ready; there is no timeout.
- If rst_n asserts at any point, the in-flight operation is discarded with no response, and all outputs return to reset values immediately (asynchronous).
- Simultaneous valids on the first cycle after reset: requester 0 wins.

## Configuration
- Macro ALU_ARB_OPCHK_EN.
- Defined:
  - Opcodes 011 and 111 are illegal.
  - On accept of an illegal opcode, the block skips EXEC and goes IDLE→RESP directly. The response has resp_err=1, resp_result=0, resp_zero=1, and alu_* are left unchanged. Latency is resp_valid in N+1.
  - Legal ops have resp_err=0.
- Undefined: all opcodes are forwarded to the ALU and sequenced normally, resp_err is tied to 0, and resp_result is whatever the ALU returns.

## Test plan
- **Single request, ADD:** reset, then r0: op 000, a=5, b=7. Expect r0_ready in cycle N, resp_valid=01 in N+2, resp_result=12, resp_zero=0.
- **Simultaneous requests:** r0 SUB 9-9 and r1 XOR 0xF0F0^0x0FF0, both valid at once after reset.
  - r0 wins first: result 0, zero=1.
  - Then r1: result 0x0000FF00.
  - Then two more simultaneous requests: r0 wins again, confirming the pointer alternates.
- **Response backpressure:** hold resp_ready=00 for 5 cycles after resp_valid. Outputs stay stable, no new ready is issued, and busy=1. On resp_ready=01, the next cycle is IDLE.
- **Wrong-owner ready:** with resp_valid=10 and resp_ready=01, no handshake occurs and state stays RESP.
- **Reset mid-operation:** pulse rst_n low in EXEC. All outputs are 0 asynchronously, no response follows, and `prio`=0.
- **Illegal opcode:** r1 op 111 with ALU_ARB_OPCHK_EN defined gives resp_valid=10 in N+1, resp_err=1, resp_result=0, resp_zero=1. With the macro undefined, the response arrives in N+2 with resp_err=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Optional illegal-opcode check enabled by defining ALU_ARB_OPCHK_EN.
//
// state | meaning
// IDLE  | waiting for a request; Mealy ready to the round-robin winner
// EXEC  | operands driven to the ALU; result captured on this edge
// RESP  | response held for the owner until it takes it
module alu_share_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             r0_valid,
   input  logic [2:0]       r0_op,
   input  logic [WIDTH-1:0] r0_a,
   input  logic [WIDTH-1:0] r0_b,
   output logic             r0_ready,
   input  logic             r1_valid,
   input  logic [2:0]       r1_op,
   input  logic [WIDTH-1:0] r1_a,
   input  logic [WIDTH-1:0] r1_b,
   output logic             r1_ready,
   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_zero,
   output logic             resp_err,
   output logic             busy,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q, state_d;
   logic             prio_q;
   logic             owner_q;
   logic             accept;
   logic             winner;
   logic             illegal;
   logic             resp_done;
   logic [2:0]       win_op;
   logic [WIDTH-1:0] win_a, win_b;

   always_comb begin
      r0_ready = (state_q == IDLE) && r0_valid && (!r1_valid || !prio_q);
      r1_ready = (state_q == IDLE) && r1_valid && (!r0_valid ||  prio_q);
      accept   = r0_ready || r1_ready;
      winner   = r1_ready;
      win_op   = winner ? r1_op : r0_op;
      win_a    = winner ? r1_a  : r0_a;
      win_b    = winner ? r1_b  : r0_b;
`ifdef ALU_ARB_OPCHK_EN
      illegal  = (win_op[1:0] == 2'b11);
`else
      illegal  = 1'b0;
`endif
      resp_valid = 2'b00;
      if (state_q == RESP)
         resp_valid = owner_q ? 2'b10 : 2'b01;
      resp_done = |(resp_valid & resp_ready);
      busy      = (state_q != IDLE);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = illegal ? RESP : EXEC;
         EXEC: state_d = RESP;
         RESP: if (resp_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         owner_q     <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= 3'b000;
         resp_result <= '0;
         resp_zero   <= 1'b0;
         resp_err    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            owner_q  <= winner;
            prio_q   <= ~winner;
            resp_err <= illegal;
            // Illegal ops never reach the ALU, so its drive keeps the last legal op.
            if (illegal) begin
               resp_result <= '0;
               resp_zero   <= 1'b1;
            end else begin
               alu_op <= win_op;
               alu_a  <= win_a;
               alu_b  <= win_b;
            end
         end
         if (state_q == EXEC) begin
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU model.
// Illegal-opcode expectations follow ALU_ARB_OPCHK_EN.
module tb_alu_share_arbiter;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             r0_valid, r1_valid;
   logic [2:0]       r0_op, r1_op;
   logic [WIDTH-1:0] r0_a, r0_b, r1_a, r1_b;
   logic             r0_ready, r1_ready;
   logic [1:0]       resp_valid, resp_ready;
   logic [WIDTH-1:0] resp_result;
   logic             resp_zero, resp_err, busy;
   logic [WIDTH-1:0] alu_a, alu_b, alu_result;
   logic [2:0]       alu_op;
   logic             alu_zero;

   int n_checks = 0;
   int n_fail   = 0;

   alu_share_arbiter #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b), .r0_ready(r0_ready),
      .r1_valid(r1_valid), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b), .r1_ready(r1_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
      .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   always #5 clk = ~clk;

   // Reference ALU; unknown opcodes return a marker so forwarding is visible.
   always_comb begin
      case (alu_op)
         3'b000:  alu_result = alu_a + alu_b;
         3'b100:  alu_result = alu_a - alu_b;
         3'b001:  alu_result = alu_a & alu_b;
         3'b101:  alu_result = alu_a | alu_b;
         3'b010:  alu_result = alu_a ^ alu_b;
         3'b110:  alu_result = alu_b << 16;
         default: alu_result = 32'hDEAD_BEEF;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      step();
   endtask

   // One lone request from requester req, run to completion.
   task automatic do_op(input bit req, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero);
      if (req) begin r1_valid = 1; r1_op = op; r1_a = a; r1_b = b; end
      else     begin r0_valid = 1; r0_op = op; r0_a = a; r0_b = b; end
      #1;
      check_eq("op_ready", req ? r1_ready : r0_ready, 1);
      step();
      r0_valid = 0; r1_valid = 0;
      check_eq("op_exec_busy", busy, 1);
      check_eq("op_exec_rv", resp_valid, 0);
      check_eq("op_alu_op", alu_op, op);
      check_eq("op_alu_a", alu_a, a);
      step();
      check_eq("op_rv", resp_valid, req ? 2'b10 : 2'b01);
      check_eq("op_result", resp_result, exp_res);
      check_eq("op_zero", resp_zero, exp_zero);
      check_eq("op_err", resp_err, 0);
      resp_ready = 2'b11;
      step();
      resp_ready = 2'b00;
      check_eq("op_idle", busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 0; r0_valid = 0; r1_valid = 0; resp_ready = 2'b00;
      r0_op = 0; r1_op = 0; r0_a = 0; r0_b = 0; r1_a = 0; r1_b = 0;
      #12;
      check_eq("rst_r0_ready", r0_ready, 0);
      check_eq("rst_r1_ready", r1_ready, 0);
      check_eq("rst_resp_valid", resp_valid, 0);
      check_eq("rst_result", resp_result, 0);
      check_eq("rst_zero", resp_zero, 0);
      check_eq("rst_err", resp_err, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_alu_a", alu_a, 0);
      check_eq("rst_alu_b", alu_b, 0);
      check_eq("rst_alu_op", alu_op, 0);
      rst_n = 1;
      step();

      do_op(0, 3'b000, 5, 7, 12, 0);

      // Simultaneous requests after reset: r0 first, then r1
      do_reset();
      r0_valid = 1; r0_op = 3'b100; r0_a = 9; r0_b = 9;
      r1_valid = 1; r1_op = 3'b010; r1_a = 32'hF0F0; r1_b = 32'h0FF0;
      #1;
      check_eq("sim_r0_wins", r0_ready, 1);
      check_eq("sim_r1_waits", r1_ready, 0);
      step();
      r0_valid = 0;
      check_eq("sim_exec_r1_ready", r1_ready, 0);
      step();
      check_eq("sim_rv0", resp_valid, 2'b01);
      check_eq("sim_sub_result", resp_result, 0);
      check_eq("sim_sub_zero", resp_zero, 1);
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("bp_rv", resp_valid, 2'b01);
         check_eq("bp_result", resp_result, 0);
         check_eq("bp_zero", resp_zero, 1);
         check_eq("bp_r1_ready", r1_ready, 0);
         check_eq("bp_busy", busy, 1);
      end
      resp_ready = 2'b01;
      step();
      resp_ready = 2'b00;
      check_eq("bp_back_idle", busy, 0);
      check_eq("sim_r1_granted", r1_ready, 1);
      step();
      r1_valid = 0;
      step();
      check_eq("sim_rv1", resp_valid, 2'b10);
      check_eq("sim_xor_result", resp_result, 32'h0000_FF00);
      check_eq("sim_xor_zero", resp_zero, 0);
      resp_ready = 2'b01;
      step();
      check_eq("wrong_owner_rv", resp_valid, 2'b10);
      check_eq("wrong_owner_busy", busy, 1);
      resp_ready = 2'b10;
      step();
      resp_ready = 2'b00;
      check_eq("owner_done_idle", busy, 0);

      // Pointer has alternated back to r0
      r0_valid = 1; r0_op = 3'b000; r0_a = 1; r0_b = 2;
      r1_valid = 1; r1_op = 3'b101; r1_a = 32'h10; r1_b = 32'h01;
      #1;
      check_eq("rr_r0_again", r0_ready, 1);
      check_eq("rr_r1_waits", r1_ready, 0);
      step();
      r0_valid = 0;
      step();
      check_eq("rr_add_result", resp_result, 3);
      resp_ready = 2'b01;
      step();
      resp_ready = 2'b00;
      check_eq("rr_r1_next", r1_ready, 1);
      step();
      r1_valid = 0;
      step();
      check_eq("rr_rv1", resp_valid, 2'b10);
      check_eq("rr_or_result", resp_result, 32'h11);
      resp_ready = 2'b10;
      step();
      resp_ready = 2'b00;

      // Reset while in EXEC
      r0_valid = 1; r0_op = 3'b001; r0_a = 32'hFF; r0_b = 32'h0F;
      #1;
      check_eq("mid_ready", r0_ready, 1);
      step();
      r0_valid = 0;
      check_eq("mid_in_exec", busy, 1);
      rst_n = 0;
      #1;
      check_eq("mid_busy", busy, 0);
      check_eq("mid_rv", resp_valid, 0);
      check_eq("mid_alu_a", alu_a, 0);
      check_eq("mid_alu_b", alu_b, 0);
      check_eq("mid_alu_op", alu_op, 0);
      check_eq("mid_result", resp_result, 0);
      check_eq("mid_zero", resp_zero, 0);
      #2;
      rst_n = 1;
      step();
      step();
      check_eq("mid_no_resp", resp_valid, 0);
      check_eq("mid_no_busy", busy, 0);
      r0_valid = 1; r1_valid = 1;
      #1;
      check_eq("mid_prio_r0", r0_ready, 1);
      check_eq("mid_prio_r1", r1_ready, 0);
      r0_valid = 0; r1_valid = 0;

      // Illegal opcode from r1
      step();
      r1_valid = 1; r1_op = 3'b111; r1_a = 3; r1_b = 4;
      #1;
      check_eq("ill_ready", r1_ready, 1);
      step();
      r1_valid = 0;
`ifdef ALU_ARB_OPCHK_EN
      check_eq("ill_rv", resp_valid, 2'b10);
      check_eq("ill_err", resp_err, 1);
      check_eq("ill_result", resp_result, 0);
      check_eq("ill_zero", resp_zero, 1);
      check_eq("ill_alu_op", alu_op, 0);
      check_eq("ill_alu_a", alu_a, 0);
`else
      check_eq("ill_rv_exec", resp_valid, 0);
      check_eq("ill_busy", busy, 1);
      step();
      check_eq("ill_rv", resp_valid, 2'b10);
      check_eq("ill_err", resp_err, 0);
      check_eq("ill_result", resp_result, 32'hDEAD_BEEF);
      check_eq("ill_zero", resp_zero, 0);
`endif
      resp_ready = 2'b10;
      step();
      resp_ready = 2'b00;
      check_eq("ill_done", busy, 0);

      do_op(1, 3'b110, 0, 32'h1234, 32'h1234_0000, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
